// File: rtl/apb_master_bridge.sv
// APB initiator: turns a single-outstanding request/response port into APB
// SETUP/ACCESS transfers with address-window slave decode and a hung-slave timeout.
module apb_master_bridge #(
  parameter int NUM_SLAVES = 4,
  parameter int SEL_LSB    = 12,
  parameter int TIMEOUT    = 16
) (
  input  logic                    HCLK,
  input  logic                    n_RST,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_addr,
  input  logic [31:0]             req_wdata,
  input  logic                    req_write,
  output logic                    rsp_valid,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_err,
  output logic [31:0]             PADDR,
  output logic [31:0]             PWDATA,
  output logic                    PWRITE,
  output logic [NUM_SLAVES-1:0]   PSEL,
  output logic                    PENABLE,
  input  logic [NUM_SLAVES*32-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]   PREADY,
  input  logic [NUM_SLAVES-1:0]   PSLVERR
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic               r_write;
  logic               r_err;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_cnt;

  logic [IDX_W-1:0]      w_idx_req;
  logic [31:0]           w_idx_ext;
  logic                  w_dec_ok;
  logic [NUM_SLAVES-1:0] w_hit;
  logic                  w_active;
  logic                  w_sel_pready;
  logic                  w_sel_pslverr;
  logic [31:0]           w_sel_prdata;

  assign w_idx_req = req_addr[SEL_LSB +: IDX_W];
  assign w_idx_ext = 32'(w_idx_req);
  assign w_dec_ok  = (w_idx_ext < 32'(NUM_SLAVES));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_hit
      assign w_hit[gi] = (r_idx == IDX_W'(gi));
    end
  endgenerate

  // Only the captured slave's handshake and data are ever looked at.
  assign w_sel_pready  = |(PREADY & w_hit);
  assign w_sel_pslverr = |(PSLVERR & w_hit);

  always_comb begin
    w_sel_prdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (w_hit[k]) w_sel_prdata = PRDATA[32*k +: 32];
    end
  end

  always_ff @(posedge HCLK or negedge n_RST) begin
    if (!n_RST) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    PENABLE      = 1'b0;
    w_active     = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_next = w_dec_ok ? S_SETUP : S_RESP;
      end
      S_SETUP: begin
        w_active     = 1'b1;
        w_state_next = S_ACCESS;
      end
      S_ACCESS: begin
        w_active = 1'b1;
        PENABLE  = 1'b1;
        if (w_sel_pready || (r_cnt == CNT_MAX)) w_state_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid    = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign PSEL      = w_active ? w_hit : '0;
  assign PADDR     = r_addr;
  assign PWDATA    = r_wdata;
  assign PWRITE    = r_write;
  assign rsp_rdata = rsp_valid ? r_rdata : 32'h0;
  assign rsp_err   = rsp_valid ? r_err : 1'b0;

  always_ff @(posedge HCLK or negedge n_RST) begin
    if (!n_RST) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr;
            r_wdata <= req_write ? req_wdata : 32'h0;
            r_write <= req_write;
            r_idx   <= w_idx_req;
            r_rdata <= '0;
            r_err   <= !w_dec_ok;
          end
        end
        S_SETUP: r_cnt <= '0;
        S_ACCESS: begin
          // PREADY wins over timeout on the last allowed cycle.
          if (w_sel_pready) begin
            r_err   <= w_sel_pslverr;
            r_rdata <= (!r_write && !w_sel_pslverr) ? w_sel_prdata : 32'h0;
          end else if (r_cnt == CNT_MAX) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
